ahb2apb_ctrl: RTL and testbench

//  AHB-Lite slave front end and APB master sequencer of the AHB-Lite to APB bridge.

---
 rtl/ahb2apb_ctrl_pkg.sv | 51 +++++
 rtl/ahb2apb_ctrl_regnb.sv | 27 ++
 rtl/ahb2apb_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ahb2apb_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2apb_ctrl_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge controller:
// HTRANS/HRESP/HSIZE encodings, FSM state codes and small decode helpers.
package ahb2apb_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
    function automatic logic is_active_trans(input logic [1:0] htrans);
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: is_active_trans = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  is_active_trans = 1'b0;
            default:                   is_active_trans = 1'b0;
        endcase
    endfunction

    // Byte lane strobes for a 32-bit APB4 bus; reads never strobe.
    function automatic logic [3:0] apb_strobe(input logic       write,
                                              input logic [2:0] hsize,
                                              input logic [1:0] addr);
        if (!write) begin
            apb_strobe = 4'b0000;
        end else begin
            case (hsize)
                HSIZE_BYTE: apb_strobe = 4'b0001 << addr;
                HSIZE_HALF: apb_strobe = 4'b0011 << {addr[1], 1'b0};
                HSIZE_WORD: apb_strobe = 4'b1111;
                default:    apb_strobe = 4'b1111;
            endcase
        end
    endfunction

endpackage

// File: rtl/ahb2apb_ctrl_regnb.sv
// Enabled holding register without reset, used for the bridge's captured
// address/control and write data.
module ahb2apb_ctrl_regnb #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Load new contents only when enabled, otherwise hold.
    always_comb begin
        data_d = en_i ? d_i : data_q;
    end

    // Plain storage flop; contents are don't-care until first load.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/ahb2apb_ctrl.sv
// AHB-Lite slave front end and APB master sequencer of the AHB-Lite to APB
// bridge. One AHB transfer is accepted, held, and replayed as one APB
// SETUP/ACCESS cycle; read data, wait states and errors return to AHB.
// Optional APB4 sideband (pstrb/pprot) is enabled by defining AHB2APB_APB4_EN.
module ahb2apb_ctrl
    import ahb2apb_ctrl_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsel_i,
    input  logic [AW-1:0] haddr_i,
    input  logic [1:0]    htrans_i,
    input  logic          hwrite_i,
    input  logic [DW-1:0] hwdata_i,
    input  logic          hready_i,
`ifdef AHB2APB_APB4_EN
    input  logic [2:0]    hsize_i,
    input  logic [3:0]    hprot_i,
`endif
    output logic          hreadyout_o,
    output logic          hresp_o,
    output logic [DW-1:0] hrdata_o,
    output logic          psel_o,
    output logic          penable_o,
    output logic          pwrite_o,
    output logic [AW-1:0] paddr_o,
    output logic [DW-1:0] pwdata_o,
`ifdef AHB2APB_APB4_EN
    output logic [DW/8-1:0] pstrb_o,
    output logic [2:0]    pprot_o,
`endif
    input  logic [DW-1:0] prdata_i,
    input  logic          pready_i,
    input  logic          pslverr_i
);

`ifdef AHB2APB_APB4_EN
    localparam int HW = AW + 1 + 3 + 2;
`else
    localparam int HW = AW + 1;
`endif

    state_e        state_d, state_q;
    logic          psel_d, psel_q;
    logic          penable_d, penable_q;
    logic          hreadyout_d, hreadyout_q;
    logic          hresp_d, hresp_q;
    logic [DW-1:0] hrdata_d, hrdata_q;

    logic          accept;
    logic          hold_en;
    logic          wdata_en;
    logic [HW-1:0] hold_d;
    logic [HW-1:0] hold_q;

    assign accept = hsel_i & hready_i & is_active_trans(htrans_i);

`ifdef AHB2APB_APB4_EN
    logic [1:0] unused_hprot;
    assign unused_hprot = hprot_i[3:2];
    assign hold_d = {hprot_i[1:0], hsize_i, hwrite_i, haddr_i};
`else
    assign hold_d = {hwrite_i, haddr_i};
`endif

    ahb2apb_ctrl_regnb #(.W(HW)) u_hold_addr (
        .clk  (clk),
        .en_i (hold_en),
        .d_i  (hold_d),
        .q_o  (hold_q)
    );

    ahb2apb_ctrl_regnb #(.W(DW)) u_hold_wdata (
        .clk  (clk),
        .en_i (wdata_en),
        .d_i  (hwdata_i),
        .q_o  (pwdata_o)
    );

    assign paddr_o  = hold_q[AW-1:0];
    assign pwrite_o = hold_q[AW];

`ifdef AHB2APB_APB4_EN
    assign pprot_o = {~hold_q[AW+4], 1'b1, hold_q[AW+5]};
    assign pstrb_o = apb_strobe(pwrite_o, hold_q[AW+3:AW+1], paddr_o[1:0]);
`endif

    // Next state, holding-register loads, read-data capture and the
    // registered AHB/APB handshake outputs derived from the next state.
    always_comb begin
        state_d  = state_q;
        hrdata_d = hrdata_q;
        hold_en  = 1'b0;
        wdata_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    hold_en = 1'b1;
                    state_d = hwrite_i ? ST_WDATA : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: begin
                wdata_en = 1'b1;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    if (pslverr_i) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_IDLE;
                        if (!pwrite_o) begin
                            hrdata_d = prdata_i;
                        end
                    end
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign hreadyout_o = hreadyout_q;
    assign hresp_o     = hresp_q;
    assign hrdata_o    = hrdata_q;

endmodule

// File: tb/tb_ahb2apb_ctrl.sv
// Self-checking bench for ahb2apb_ctrl: directed scenarios plus randomized
// transfers checked against a transaction-level expectation model.
// AHB2APB_APB4_EN adds the APB4 sideband scenario.
module tb_ahb2apb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hsel_i = 1'b0;
    logic [15:0] haddr_i = '0;
    logic [1:0]  htrans_i = 2'b00;
    logic        hwrite_i = 1'b0;
    logic [31:0] hwdata_i = '0;
    logic        hready_i;
    logic        hreadyout_o;
    logic        hresp_o;
    logic [31:0] hrdata_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [15:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;
`ifdef AHB2APB_APB4_EN
    logic [2:0]  hsize_i = 3'b010;
    logic [3:0]  hprot_i = 4'b0000;
    logic [3:0]  pstrb_o;
    logic [2:0]  pprot_o;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [31:0] exp_hrdata = '0;

    assign hready_i = hreadyout_o;

    always #5 clk = ~clk;

    ahb2apb_ctrl #(.AW(16), .DW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsel_i      (hsel_i),
        .haddr_i     (haddr_i),
        .htrans_i    (htrans_i),
        .hwrite_i    (hwrite_i),
        .hwdata_i    (hwdata_i),
        .hready_i    (hready_i),
`ifdef AHB2APB_APB4_EN
        .hsize_i     (hsize_i),
        .hprot_i     (hprot_i),
`endif
        .hreadyout_o (hreadyout_o),
        .hresp_o     (hresp_o),
        .hrdata_o    (hrdata_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
`ifdef AHB2APB_APB4_EN
        .pstrb_o     (pstrb_o),
        .pprot_o     (pprot_o),
`endif
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i)
    );

    typedef struct {
        int          low;
        int          pen;
        int          hresp_low;
        logic        seen_setup;
        logic [15:0] s_addr;
        logic        s_write;
        logic [31:0] s_wdata;
        logic        stable;
        logic        resp_end;
        logic [31:0] rdata_end;
        int          setup_cyc;
        int          end_cyc;
        logic        timeout;
        logic [3:0]  s_pstrb;
        logic [2:0]  s_pprot;
    } obs_t;

    // Drives one AHB transfer and plays the APB slave; records what was seen.
    task automatic drive_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                              input int waits, input logic err, input logic [31:0] rdata,
                              output obs_t o);
        int wait_cnt;
        wait_cnt = 0;
        o.low = 0; o.pen = 0; o.hresp_low = 0; o.seen_setup = 1'b0;
        o.s_addr = '0; o.s_write = 1'b0; o.s_wdata = '0; o.stable = 1'b1;
        o.resp_end = 1'b0; o.rdata_end = '0; o.setup_cyc = -1; o.end_cyc = 0;
        o.timeout = 1'b0; o.s_pstrb = '0; o.s_pprot = '0;
        pready_i = 1'b0; pslverr_i = 1'b0;
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = addr; hwrite_i = wr;
        @(negedge clk); cyc++;
        hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = wdata;
        haddr_i = 16'($urandom); hwrite_i = 1'($urandom);
        while (hreadyout_o !== 1'b1 && o.low < 64) begin
            o.low++;
            if (hresp_o === 1'b1) o.hresp_low++;
            pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
            if (psel_o === 1'b1 && penable_o === 1'b0) begin
                o.seen_setup = 1'b1; o.setup_cyc = cyc;
                o.s_addr = paddr_o; o.s_write = pwrite_o; o.s_wdata = pwdata_o;
`ifdef AHB2APB_APB4_EN
                o.s_pstrb = pstrb_o; o.s_pprot = pprot_o;
`endif
            end else if (psel_o === 1'b1 && penable_o === 1'b1) begin
                o.pen++;
                if (paddr_o !== o.s_addr || pwrite_o !== o.s_write || (wr && pwdata_o !== o.s_wdata))
                    o.stable = 1'b0;
                if (wait_cnt >= waits) begin
                    pready_i = 1'b1; pslverr_i = err; prdata_i = rdata;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk); cyc++;
        end
        o.timeout = (hreadyout_o !== 1'b1);
        pready_i = 1'b0; pslverr_i = 1'b0;
        o.resp_end = hresp_o; o.rdata_end = hrdata_o; o.end_cyc = cyc;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (hreadyout_o !== 1'b1 || hresp_o !== 1'b0 || psel_o !== 1'b0 || penable_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got rdy=%b resp=%b psel=%b pen=%b required 1 0 0 0",
                     hreadyout_o, hresp_o, psel_o, penable_o);
        end
        vectors++;
        if (hrdata_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_hrdata: got %h required 0", hrdata_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); cyc++;
        vectors++;
        if (hreadyout_o !== 1'b1 || psel_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got rdy=%b psel=%b required 1 0", hreadyout_o, psel_o);
        end
        exp_hrdata = '0;
    endtask

    task automatic test_read_basic();
        obs_t o;
        drive_xfer(1'b0, 16'h0010, 32'h0, 0, 1'b0, 32'hA5A5_0001, o);
        exp_hrdata = 32'hA5A5_0001;
        vectors++;
        if (o.timeout || !o.seen_setup || o.s_addr !== 16'h0010 || o.s_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_setup: got to=%b setup=%b addr=%h wr=%b required 0 1 0010 0",
                     o.timeout, o.seen_setup, o.s_addr, o.s_write);
        end
        vectors++;
        if (o.low !== 2 || o.pen !== 1) begin
            miscompares++;
            $display("[TB] FAIL read_latency: got low=%0d pen=%0d required 2 1", o.low, o.pen);
        end
        vectors++;
        if (o.rdata_end !== exp_hrdata || o.resp_end !== 1'b0 || o.hresp_low !== 0) begin
            miscompares++;
            $display("[TB] FAIL read_data: got %h resp=%b required %h 0", o.rdata_end, o.resp_end, exp_hrdata);
        end
    endtask

    task automatic test_write_wait();
        obs_t o;
        drive_xfer(1'b1, 16'h0020, 32'hDEAD_BEEF, 3, 1'b0, 32'h1234_5678, o);
        vectors++;
        if (o.s_addr !== 16'h0020 || o.s_write !== 1'b1 || o.s_wdata !== 32'hDEAD_BEEF || !o.stable) begin
            miscompares++;
            $display("[TB] FAIL write_apb: got addr=%h wr=%b data=%h stable=%b required 0020 1 deadbeef 1",
                     o.s_addr, o.s_write, o.s_wdata, o.stable);
        end
        vectors++;
        if (o.low !== 6 || o.pen !== 4) begin
            miscompares++;
            $display("[TB] FAIL write_latency: got low=%0d pen=%0d required 6 4", o.low, o.pen);
        end
        vectors++;
        if (o.rdata_end !== exp_hrdata || o.resp_end !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_hrdata_hold: got %h resp=%b required %h 0", o.rdata_end, o.resp_end, exp_hrdata);
        end
    endtask

    task automatic test_error();
        obs_t o;
        drive_xfer(1'b0, 16'h0030, 32'h0, 0, 1'b1, 32'hBAD0_BAD0, o);
        vectors++;
        if (o.low !== 3 || o.hresp_low !== 1 || o.resp_end !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL error_resp: got low=%0d resp_low=%0d resp_end=%b required 3 1 1",
                     o.low, o.hresp_low, o.resp_end);
        end
        vectors++;
        if (o.rdata_end !== exp_hrdata) begin
            miscompares++;
            $display("[TB] FAIL error_hrdata: got %h required %h", o.rdata_end, exp_hrdata);
        end
        @(negedge clk); cyc++;
        vectors++;
        if (hresp_o !== 1'b0 || hreadyout_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL error_recover: got resp=%b rdy=%b required 0 1", hresp_o, hreadyout_o);
        end
    endtask

    task automatic test_no_action();
        logic [1:0] tr_tab [3] = '{2'b01, 2'b10, 2'b00};
        logic       sel_tab [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            hsel_i = sel_tab[i]; htrans_i = tr_tab[i]; haddr_i = 16'h0100; hwrite_i = 1'b0;
            @(negedge clk); cyc++;
            vectors++;
            if (psel_o !== 1'b0 || hreadyout_o !== 1'b1 || hresp_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL no_action_%0d: got psel=%b rdy=%b resp=%b required 0 1 0",
                         i, psel_o, hreadyout_o, hresp_o);
            end
        end
        hsel_i = 1'b0; htrans_i = 2'b00;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        drive_xfer(1'b1, 16'h0004, 32'hCAFE_0004, 0, 1'b0, 32'h0, o1);
        drive_xfer(1'b0, 16'h0008, 32'h0, 0, 1'b0, 32'h5555_0008, o2);
        exp_hrdata = 32'h5555_0008;
        vectors++;
        if (o2.setup_cyc !== o1.end_cyc + 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap: got setup at %0d required %0d", o2.setup_cyc, o1.end_cyc + 1);
        end
        vectors++;
        if (o1.s_wdata !== 32'hCAFE_0004 || o2.s_addr !== 16'h0008 || o2.rdata_end !== exp_hrdata) begin
            miscompares++;
            $display("[TB] FAIL b2b_data: got wdata=%h addr=%h rdata=%h required cafe0004 0008 %h",
                     o1.s_wdata, o2.s_addr, o2.rdata_end, exp_hrdata);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int n = 0; n < 40; n++) begin
            logic        wr;
            logic        err;
            logic [15:0] addr;
            logic [31:0] wdata, rdata;
            int          waits;
            wr    = 1'($urandom_range(0, 1));
            err   = ($urandom_range(0, 5) == 0);
            addr  = 16'($urandom);
            wdata = $urandom;
            rdata = $urandom;
            waits = $urandom_range(0, 3);
            drive_xfer(wr, addr, wdata, waits, err, rdata, o);
            if (!wr && !err) exp_hrdata = rdata;
            vectors++;
            if (o.timeout || o.low !== (wr ? 3 : 2) + waits + (err ? 1 : 0) || o.pen !== waits + 1) begin
                miscompares++;
                $display("[TB] FAIL rand_latency_%0d: got low=%0d pen=%0d required %0d %0d", n, o.low, o.pen,
                         (wr ? 3 : 2) + waits + (err ? 1 : 0), waits + 1);
            end
            vectors++;
            if (o.s_addr !== addr || o.s_write !== wr || !o.stable || (wr && o.s_wdata !== wdata)) begin
                miscompares++;
                $display("[TB] FAIL rand_apb_%0d: got addr=%h wr=%b data=%h stable=%b required %h %b %h 1",
                         n, o.s_addr, o.s_write, o.s_wdata, o.stable, addr, wr, wdata);
            end
            vectors++;
            if (o.resp_end !== err || o.hresp_low !== (err ? 1 : 0) || o.rdata_end !== exp_hrdata) begin
                miscompares++;
                $display("[TB] FAIL rand_resp_%0d: got resp=%b resp_low=%0d rdata=%h required %b %0d %h",
                         n, o.resp_end, o.hresp_low, o.rdata_end, err, err ? 1 : 0, exp_hrdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   guard;
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 16'h0040; hwrite_i = 1'b0;
        @(negedge clk); cyc++;
        hsel_i = 1'b0; htrans_i = 2'b00;
        pready_i = 1'b0;
        guard = 0;
        while (penable_o !== 1'b1 && guard < 8) begin
            @(negedge clk); cyc++; guard++;
        end
        vectors++;
        if (penable_o !== 1'b1 || psel_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_access: got psel=%b pen=%b required 1 1", psel_o, penable_o);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || hreadyout_o !== 1'b1 || hresp_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got psel=%b pen=%b rdy=%b resp=%b required 0 0 1 0",
                     psel_o, penable_o, hreadyout_o, hresp_o);
        end
        vectors++;
        if (hrdata_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_hrdata: got %h required 0", hrdata_o);
        end
        exp_hrdata = '0;
        @(negedge clk); cyc++;
        rst_n = 1'b1;
        @(negedge clk); cyc++;
        drive_xfer(1'b0, 16'h0044, 32'h0, 0, 1'b0, 32'h7777_0044, o);
        exp_hrdata = 32'h7777_0044;
        vectors++;
        if (o.low !== 2 || o.s_addr !== 16'h0044 || o.rdata_end !== exp_hrdata || o.resp_end !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_read: got low=%0d addr=%h rdata=%h resp=%b required 2 0044 %h 0",
                     o.low, o.s_addr, o.rdata_end, o.resp_end, exp_hrdata);
        end
    endtask

`ifdef AHB2APB_APB4_EN
    task automatic test_apb4();
        obs_t o;
        hsize_i = 3'b000; hprot_i = 4'b0011;
        drive_xfer(1'b1, 16'h0003, 32'h1100_0000, 0, 1'b0, 32'h0, o);
        vectors++;
        if (o.s_pstrb !== 4'b1000 || o.s_pprot !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL apb4_byte: got pstrb=%b pprot=%b required 1000 011", o.s_pstrb, o.s_pprot);
        end
        hsize_i = 3'b001; hprot_i = 4'b0000;
        drive_xfer(1'b1, 16'h0002, 32'h2200_0000, 0, 1'b0, 32'h0, o);
        vectors++;
        if (o.s_pstrb !== 4'b1100 || o.s_pprot !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL apb4_half: got pstrb=%b pprot=%b required 1100 110", o.s_pstrb, o.s_pprot);
        end
        hsize_i = 3'b010;
        drive_xfer(1'b0, 16'h0004, 32'h0, 0, 1'b0, 32'h3300_0004, o);
        exp_hrdata = 32'h3300_0004;
        vectors++;
        if (o.s_pstrb !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL apb4_read_strb: got %b required 0000", o.s_pstrb);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write_wait();
        test_error();
        test_no_action();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef AHB2APB_APB4_EN
        test_apb4();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
